// File: rtl/mem_copy_sequencer.sv
// rtl/mem_copy_sequencer.sv - sequences an Avalon-MM read/write master pair to copy an SDRAM block
// Optional: define MEM_COPY_CHECKSUM_EN to add a running additive checksum of the copied words.
module mem_copy_sequencer #(
   parameter int ADDRESSWIDTH = 28,
   parameter int DATAWIDTH    = 32
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    start,
   input  logic [ADDRESSWIDTH-1:0] src_base,
   input  logic [ADDRESSWIDTH-1:0] dst_base,
   input  logic [ADDRESSWIDTH-1:0] length,
   output logic                    busy,
   output logic                    done,
   output logic [ADDRESSWIDTH-1:0] words_moved,
   output logic                    rd_fixed_location,
   output logic [ADDRESSWIDTH-1:0] rd_base,
   output logic [ADDRESSWIDTH-1:0] rd_length,
   output logic                    rd_go,
   input  logic                    rd_done,
   output logic                    rd_buffer,
   input  logic [DATAWIDTH-1:0]    rd_data,
   input  logic                    rd_data_available,
   output logic                    wr_fixed_location,
   output logic [ADDRESSWIDTH-1:0] wr_base,
   output logic [ADDRESSWIDTH-1:0] wr_length,
   output logic                    wr_go,
   input  logic                    wr_done,
   output logic                    wr_buffer,
   output logic [DATAWIDTH-1:0]    wr_data,
`ifdef MEM_COPY_CHECKSUM_EN
   output logic [DATAWIDTH-1:0]    checksum,
`endif
   input  logic                    wr_buffer_full
);

   localparam int BYTES = DATAWIDTH / 8;
   localparam int SHIFT = (BYTES > 1) ? $clog2(BYTES) : 0;
   localparam logic [ADDRESSWIDTH-1:0] ONE = 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LAUNCH,
      S_STREAM,
      S_DRAIN,
      S_FINISH
   } state_t;

   state_t                  state_q;
   logic                    busy_q;
   logic                    done_q;
   logic                    rd_go_q;
   logic                    wr_go_q;
   logic                    rd_seen_q;
   logic                    wr_seen_q;
   logic [ADDRESSWIDTH-1:0] words_q;
   logic [ADDRESSWIDTH-1:0] len_words_q;
   logic [ADDRESSWIDTH-1:0] rd_base_q;
   logic [ADDRESSWIDTH-1:0] wr_base_q;
   logic [ADDRESSWIDTH-1:0] len_words_d;
   logic [ADDRESSWIDTH-1:0] words_d;
   logic                    xfer;
   logic                    masters_done;
`ifdef MEM_COPY_CHECKSUM_EN
   logic [DATAWIDTH-1:0]    checksum_q;
   assign checksum = checksum_q;
`endif

   assign len_words_d = length >> SHIFT;
   assign words_d     = words_q + ONE;
   assign xfer        = (state_q == S_STREAM) & rd_data_available & ~wr_buffer_full
                        & (words_q < len_words_q);
   // A master done seen in this very cycle counts, so done trails the later one by one cycle.
   assign masters_done = (rd_seen_q | rd_done) & (wr_seen_q | wr_done);

   assign rd_buffer         = xfer;
   assign wr_buffer         = xfer;
   assign wr_data           = (state_q == S_STREAM) ? rd_data : '0;
   assign rd_fixed_location = 1'b0;
   assign wr_fixed_location = 1'b0;
   assign busy              = busy_q;
   assign done              = done_q;
   assign rd_go             = rd_go_q;
   assign wr_go             = wr_go_q;
   assign words_moved       = words_q;
   assign rd_base           = rd_base_q;
   assign wr_base           = wr_base_q;
   assign rd_length         = len_words_q << SHIFT;
   assign wr_length         = len_words_q << SHIFT;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         rd_go_q     <= 1'b0;
         wr_go_q     <= 1'b0;
         rd_seen_q   <= 1'b0;
         wr_seen_q   <= 1'b0;
         words_q     <= '0;
         len_words_q <= '0;
         rd_base_q   <= '0;
         wr_base_q   <= '0;
`ifdef MEM_COPY_CHECKSUM_EN
         checksum_q  <= '0;
`endif
      end else begin
         rd_go_q <= 1'b0;
         wr_go_q <= 1'b0;
         done_q  <= 1'b0;
         // Either master may finish before streaming does, so remember it.
         if (state_q != S_IDLE) begin
            if (rd_done) rd_seen_q <= 1'b1;
            if (wr_done) wr_seen_q <= 1'b1;
         end
         if (xfer) begin
            words_q <= words_d;
`ifdef MEM_COPY_CHECKSUM_EN
            checksum_q <= checksum_q + rd_data;
`endif
         end
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  rd_base_q   <= src_base;
                  wr_base_q   <= dst_base;
                  len_words_q <= len_words_d;
                  words_q     <= '0;
                  busy_q      <= 1'b1;
`ifdef MEM_COPY_CHECKSUM_EN
                  checksum_q  <= '0;
`endif
                  state_q     <= (len_words_d == '0) ? S_FINISH : S_LAUNCH;
               end
            end
            S_LAUNCH: begin
               rd_go_q   <= 1'b1;
               wr_go_q   <= 1'b1;
               rd_seen_q <= 1'b0;
               wr_seen_q <= 1'b0;
               state_q   <= S_STREAM;
            end
            S_STREAM: begin
               if (xfer && (words_d == len_words_q)) state_q <= S_DRAIN;
            end
            S_DRAIN: begin
               if (masters_done) begin
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end
            end
            S_FINISH: begin
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_copy_sequencer.sv
// tb/tb_mem_copy_sequencer.sv - directed self-checking bench for mem_copy_sequencer
module tb_mem_copy_sequencer;

   localparam int AW = 28;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          start = 1'b0;
   logic [AW-1:0] src_base = '0;
   logic [AW-1:0] dst_base = '0;
   logic [AW-1:0] length = '0;
   logic          busy, done;
   logic [AW-1:0] words_moved;
   logic          rd_fixed_location, wr_fixed_location;
   logic [AW-1:0] rd_base, rd_length, wr_base, wr_length;
   logic          rd_go, wr_go, rd_buffer, wr_buffer;
   logic          rd_done = 1'b0;
   logic          wr_done = 1'b0;
   logic          wr_buffer_full = 1'b0;
   logic [DW-1:0] rd_data, wr_data;
   logic          rd_data_available;
`ifdef MEM_COPY_CHECKSUM_EN
   logic [DW-1:0] checksum;
`endif

   logic [DW-1:0] mem [0:63];
   logic [DW-1:0] cap [0:63];
   int            rd_idx = 0;
   int            rd_cnt = 0;
   int            cap_n = 0;
   int            rd_go_n = 0;
   int            wr_go_n = 0;
   int            done_n = 0;
   int            bad_n = 0;
   logic [AW-1:0] go_rd_len = '0;
   logic [AW-1:0] go_wr_len = '0;
   logic          avail_en = 1'b0;
   logic          flush = 1'b0;
   int            errors = 0;
   int            checks = 0;

   always #5 clk = ~clk;

   mem_copy_sequencer #(.ADDRESSWIDTH(AW), .DATAWIDTH(DW)) dut (
      .clk(clk), .reset_n(reset_n), .start(start),
      .src_base(src_base), .dst_base(dst_base), .length(length),
      .busy(busy), .done(done), .words_moved(words_moved),
      .rd_fixed_location(rd_fixed_location), .rd_base(rd_base), .rd_length(rd_length),
      .rd_go(rd_go), .rd_done(rd_done), .rd_buffer(rd_buffer), .rd_data(rd_data),
      .rd_data_available(rd_data_available),
      .wr_fixed_location(wr_fixed_location), .wr_base(wr_base), .wr_length(wr_length),
      .wr_go(wr_go), .wr_done(wr_done), .wr_buffer(wr_buffer), .wr_data(wr_data),
`ifdef MEM_COPY_CHECKSUM_EN
      .checksum(checksum),
`endif
      .wr_buffer_full(wr_buffer_full)
   );

   // Show-ahead read buffer model and write-side capture
   assign rd_data_available = avail_en && (rd_idx < rd_cnt);
   assign rd_data = (rd_idx < rd_cnt) ? mem[rd_idx[5:0]] : '0;

   always @(posedge clk) begin
      if (flush) rd_idx <= rd_cnt;
      else if (rd_buffer) rd_idx <= rd_idx + 1;
      if (wr_buffer) begin
         cap[cap_n[5:0]] <= wr_data;
         cap_n <= cap_n + 1;
      end
      if (rd_go) begin
         rd_go_n <= rd_go_n + 1;
         go_rd_len <= rd_length;
      end
      if (wr_go) begin
         wr_go_n <= wr_go_n + 1;
         go_wr_len <= wr_length;
      end
      if (done) done_n <= done_n + 1;
      if ((rd_buffer && wr_buffer_full) || (rd_buffer != wr_buffer)) bad_n <= bad_n + 1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_word(input logic [DW-1:0] w);
      mem[rd_cnt[5:0]] = w;
      rd_cnt = rd_cnt + 1;
   endtask

   task automatic do_flush();
      flush = 1'b1;
      tick();
      flush = 1'b0;
   endtask

   task automatic do_start(input logic [AW-1:0] s, input logic [AW-1:0] d, input logic [AW-1:0] l);
      src_base = s;
      dst_base = d;
      length = l;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_words(input logic [AW-1:0] n, input int max, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < max; i++) begin
         if (words_moved == n) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      if (words_moved == n) ok = 1'b1;
   endtask

   task automatic pulse_dones(input logic r, input logic w);
      rd_done = r;
      wr_done = w;
      tick();
      rd_done = 1'b0;
      wr_done = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (2) tick();
      checks++;
      if ({busy, done, rd_go, wr_go, rd_buffer, wr_buffer, rd_fixed_location, wr_fixed_location} !== 8'h00)
         begin errors++; $display("FAIL reset_ctrl: got %b want 00000000",
            {busy, done, rd_go, wr_go, rd_buffer, wr_buffer, rd_fixed_location, wr_fixed_location}); end
      checks++;
      if ({words_moved, rd_base, rd_length, wr_base, wr_length, wr_data} !== '0)
         begin errors++; $display("FAIL reset_data: words=%0d rd_base=%h rd_len=%0d wr_base=%h wr_len=%0d wr_data=%h want all 0",
            words_moved, rd_base, rd_length, wr_base, wr_length, wr_data); end
      reset_n = 1'b1;
      tick();
   endtask

   task automatic test_basic_copy();
      int c0, g0, w0, d0;
      bit ok;
      do_flush();
      for (int i = 0; i < 4; i++) push_word(32'h11 * (i + 1));
      c0 = cap_n; g0 = rd_go_n; w0 = wr_go_n; d0 = done_n;
      avail_en = 1'b1;
      do_start(28'h100, 28'h800, 28'd16);
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b want 1", busy); end
      tick();
      checks++;
      if ({rd_go, wr_go, rd_length, wr_length, rd_base, wr_base} !== {1'b1, 1'b1, 28'd16, 28'd16, 28'h100, 28'h800})
         begin errors++; $display("FAIL basic_launch: go=%b%b rd_len=%0d wr_len=%0d rd_base=%h wr_base=%h want 11 16 16 100 800",
            rd_go, wr_go, rd_length, wr_length, rd_base, wr_base); end
      wait_words(28'd4, 20, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL basic_words: got %0d want 4", words_moved); end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (cap[(c0 + i) % 64] !== 32'h11 * (i + 1))
            begin errors++; $display("FAIL basic_data[%0d]: got %h want %h", i, cap[(c0 + i) % 64], 32'h11 * (i + 1)); end
      end
      pulse_dones(1'b1, 1'b1);
      checks++;
      if ({done, busy, words_moved} !== {1'b1, 1'b0, 28'd4})
         begin errors++; $display("FAIL basic_done: done=%b busy=%b words=%0d want 1 0 4", done, busy, words_moved); end
      tick();
      checks++;
      if ({done, rd_go_n - g0, wr_go_n - w0, done_n - d0, go_rd_len, go_wr_len, cap_n - c0} !==
          {1'b0, 32'd1, 32'd1, 32'd1, 28'd16, 28'd16, 32'd4})
         begin errors++; $display("FAIL basic_counts: done=%b rd_go=%0d wr_go=%0d dones=%0d glen=%0d/%0d pushes=%0d want 0 1 1 1 16/16 4",
            done, rd_go_n - g0, wr_go_n - w0, done_n - d0, go_rd_len, go_wr_len, cap_n - c0); end
   endtask

   task automatic test_backpressure();
      int c0, b0;
      logic [AW-1:0] wm;
      bit ok;
      do_flush();
      for (int i = 0; i < 8; i++) push_word(32'hA1 + i);
      c0 = cap_n;
      avail_en = 1'b1;
      do_start(28'h1000, 28'h2000, 28'd32);
      repeat (3) tick();
      wr_buffer_full = 1'b1;
      wm = words_moved;
      b0 = bad_n;
      repeat (5) tick();
      checks++;
      if ({words_moved, bad_n - b0} !== {wm, 32'd0})
         begin errors++; $display("FAIL bp_stall: words=%0d bad=%0d want %0d 0", words_moved, bad_n - b0, wm); end
      wr_buffer_full = 1'b0;
      wait_words(28'd8, 30, ok);
      checks++;
      if (!ok || cap_n - c0 != 8) begin errors++; $display("FAIL bp_words: got %0d pushes %0d want 8", words_moved, cap_n - c0); end
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (cap[(c0 + i) % 64] !== 32'hA1 + i)
            begin errors++; $display("FAIL bp_data[%0d]: got %h want %h", i, cap[(c0 + i) % 64], 32'hA1 + i); end
      end
      pulse_dones(1'b1, 1'b0);
      pulse_dones(1'b0, 1'b1);
      checks++;
      if (done !== 1'b1) begin errors++; $display("FAIL bp_done: got %b want 1", done); end
      tick();
   endtask

   task automatic test_zero_unaligned();
      int g0, c0;
      bit ok;
      do_flush();
      g0 = rd_go_n; c0 = cap_n;
      do_start(28'h40, 28'h80, 28'd0);
      checks++;
      if ({done, busy} !== 2'b01) begin errors++; $display("FAIL zero_cycle1: done=%b busy=%b want 0 1", done, busy); end
      tick();
      checks++;
      if ({done, busy} !== 2'b10) begin errors++; $display("FAIL zero_done: done=%b busy=%b want 1 0", done, busy); end
      tick();
      checks++;
      if ({rd_go_n - g0, cap_n - c0} !== {32'd0, 32'd0})
         begin errors++; $display("FAIL zero_traffic: gos=%0d pushes=%0d want 0 0", rd_go_n - g0, cap_n - c0); end
      push_word(32'h77);
      push_word(32'h78);
      avail_en = 1'b1;
      do_start(28'h40, 28'h80, 28'd7);
      tick();
      checks++;
      if ({rd_length, wr_length} !== {28'd4, 28'd4})
         begin errors++; $display("FAIL unal_len: rd=%0d wr=%0d want 4 4", rd_length, wr_length); end
      wait_words(28'd1, 10, ok);
      repeat (3) tick();
      checks++;
      if (!ok || words_moved !== 28'd1 || cap_n - c0 != 1 || cap[c0 % 64] !== 32'h77)
         begin errors++; $display("FAIL unal_move: words=%0d pushes=%0d first=%h want 1 1 77",
            words_moved, cap_n - c0, cap[c0 % 64]); end
      pulse_dones(1'b1, 1'b1);
      checks++;
      if (done !== 1'b1) begin errors++; $display("FAIL unal_done: got %b want 1", done); end
      tick();
   endtask

   task automatic test_early_done();
      int d0;
      bit ok;
      do_flush();
      push_word(32'hB1);
      push_word(32'hB2);
      avail_en = 1'b0;
      do_start(28'h300, 28'h500, 28'd8);
      tick();
      pulse_dones(1'b1, 1'b0);
      avail_en = 1'b1;
      wait_words(28'd2, 10, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL early_words: got %0d want 2", words_moved); end
      d0 = done_n;
      repeat (9) tick();
      checks++;
      if ({done_n - d0, busy} !== {32'd0, 1'b1})
         begin errors++; $display("FAIL early_wait: dones=%0d busy=%b want 0 1", done_n - d0, busy); end
      pulse_dones(1'b0, 1'b1);
      checks++;
      if ({done, done_n - d0} !== {1'b1, 32'd0})
         begin errors++; $display("FAIL early_done: done=%b prior=%0d want 1 0", done, done_n - d0); end
      tick();
   endtask

   task automatic test_busy_start_and_reset();
      int g0, c0;
      bit ok;
      do_flush();
      for (int i = 0; i < 8; i++) push_word(32'hC1 + i);
      avail_en = 1'b1;
      do_start(28'h200, 28'h400, 28'd32);
      do_start(28'h900, 28'h990, 28'd4);
      checks++;
      if ({rd_base, wr_base, rd_length, busy} !== {28'h200, 28'h400, 28'd32, 1'b1})
         begin errors++; $display("FAIL busy_start: rd_base=%h wr_base=%h len=%0d busy=%b want 200 400 32 1",
            rd_base, wr_base, rd_length, busy); end
      wait_words(28'd2, 10, ok);
      avail_en = 1'b0;
      reset_n = 1'b0;
      tick();
      checks++;
      if (!ok || {busy, done, rd_go, wr_go, rd_buffer, wr_buffer, words_moved, rd_base, rd_length, wr_base, wr_length, wr_data} !== '0)
         begin errors++; $display("FAIL midreset: ok=%b busy=%b done=%b words=%0d rd_base=%h wr_base=%h len=%0d buf=%b%b want all 0",
            ok, busy, done, words_moved, rd_base, wr_base, rd_length, rd_buffer, wr_buffer); end
      tick();
      reset_n = 1'b1;
      g0 = rd_go_n; c0 = cap_n;
      avail_en = 1'b1;
      repeat (3) tick();
      checks++;
      if ({rd_go_n - g0, cap_n - c0, busy} !== {32'd0, 32'd0, 1'b0})
         begin errors++; $display("FAIL post_reset_quiet: gos=%0d pushes=%0d busy=%b want 0 0 0", rd_go_n - g0, cap_n - c0, busy); end
      do_flush();
      push_word(32'h5A);
      c0 = cap_n;
      do_start(28'h10, 28'h20, 28'd4);
      tick();
      checks++;
      if ({rd_go, wr_go, rd_base, wr_base} !== {2'b11, 28'h10, 28'h20})
         begin errors++; $display("FAIL restart_go: go=%b%b rd_base=%h wr_base=%h want 11 10 20", rd_go, wr_go, rd_base, wr_base); end
      wait_words(28'd1, 10, ok);
      pulse_dones(1'b1, 1'b1);
      checks++;
      if (!ok || done !== 1'b1 || cap[c0 % 64] !== 32'h5A)
         begin errors++; $display("FAIL restart_done: done=%b data=%h want 1 5a", done, cap[c0 % 64]); end
      tick();
   endtask

`ifdef MEM_COPY_CHECKSUM_EN
   task automatic test_checksum();
      bit ok;
      do_flush();
      push_word(32'hFFFF_FFFF);
      push_word(32'h0000_0002);
      avail_en = 1'b0;
      do_start(28'h600, 28'h700, 28'd8);
      checks++;
      if (checksum !== 32'h0) begin errors++; $display("FAIL csum_clear: got %h want 0", checksum); end
      avail_en = 1'b1;
      wait_words(28'd2, 10, ok);
      pulse_dones(1'b1, 1'b1);
      checks++;
      if (!ok || done !== 1'b1 || checksum !== 32'h1)
         begin errors++; $display("FAIL csum_value: done=%b got %h want 00000001", done, checksum); end
      tick();
   endtask
`endif

   initial begin
      test_reset();
      test_basic_copy();
      test_backpressure();
      test_zero_unaligned();
      test_early_done();
      test_busy_start_and_reset();
`ifdef MEM_COPY_CHECKSUM_EN
      test_checksum();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
